demux1to2_32_buf: RTL and testbench

//   Buffered 1-to-2 demultiplexer: the steering counterpart of the 2-to-1 datapath muxes.

---
 rtl/demux1to2_32_buf.sv | 89 ++++++++
 tb/tb_demux1to2_32_buf.sv | 167 ++++++++++++++++
 2 files changed

// File: rtl/demux1to2_32_buf.sv
// demux1to2_32_buf
//   Buffered 1-to-2 demultiplexer. One valid/ready producer port feeds two
//   independent FIFO queues. in_select picks the destination queue of each word,
//   and each queue drains through its own valid/ready consumer port.
//
//   Ports
//     clk, rst                   system clock, asynchronous active-high reset
//     in_data/in_select          word and its destination queue (0 or 1)
//     in_valid/in_ready          producer handshake; in_ready = selected queue not full
//     out0_data/valid/ready      consumer 0 handshake; data reads 0 while the queue is empty
//     out1_data/valid/ready      consumer 1 handshake; data reads 0 while the queue is empty
//     out0_count/out1_count      number of entries held in each queue (0..DEPTH)
module demux1to2_32_buf #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 2
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [WIDTH-1:0]           in_data,
    input  logic                       in_select,
    input  logic                       in_valid,
    output logic                       in_ready,
    output logic [WIDTH-1:0]           out0_data,
    output logic                       out0_valid,
    input  logic                       out0_ready,
    output logic [WIDTH-1:0]           out1_data,
    output logic                       out1_valid,
    input  logic                       out1_ready,
    output logic [$clog2(DEPTH+1)-1:0] out0_count,
    output logic [$clog2(DEPTH+1)-1:0] out1_count
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH+1);

    logic [WIDTH-1:0]      mem [2][DEPTH];
    logic [1:0][PTR_W-1:0] head;
    logic [1:0][PTR_W-1:0] tail;
    logic [1:0][CNT_W-1:0] count;
    logic [1:0]            push;
    logic [1:0]            pop;
    logic [1:0]            valid;

    // No bypass: a full queue refuses a push even if it pops in the same cycle,
    // which keeps in_ready independent of the consumer ready inputs.
    assign in_ready = (count[in_select] != CNT_W'(DEPTH));

    always_comb begin
        valid[0] = (count[0] != '0);
        valid[1] = (count[1] != '0);
        push[0]  = in_valid & in_ready & ~in_select;
        push[1]  = in_valid & in_ready &  in_select;
        pop[0]   = valid[0] & out0_ready;
        pop[1]   = valid[1] & out1_ready;
    end

    // DEPTH is a power of two, so the pointers wrap on their own.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else begin
            for (int q = 0; q < 2; q++) begin
                if (push[q]) tail[q] <= tail[q] + PTR_W'(1);
                if (pop[q])  head[q] <= head[q] + PTR_W'(1);
                case ({push[q], pop[q]})
                    2'b10:   count[q] <= count[q] + CNT_W'(1);
                    2'b01:   count[q] <= count[q] - CNT_W'(1);
                    default: count[q] <= count[q];
                endcase
            end
        end
    end

    // Storage needs no reset: the outputs are gated to zero while a queue is empty.
    always_ff @(posedge clk) begin
        if (push[0]) mem[0][tail[0]] <= in_data;
        if (push[1]) mem[1][tail[1]] <= in_data;
    end

    assign out0_valid = valid[0];
    assign out1_valid = valid[1];
    assign out0_data  = valid[0] ? mem[0][head[0]] : '0;
    assign out1_data  = valid[1] ? mem[1][head[1]] : '0;
    assign out0_count = count[0];
    assign out1_count = count[1];

endmodule

// File: tb/tb_demux1to2_32_buf.sv
// tb_demux1to2_32_buf
//   Drives directed scenarios and random traffic into demux1to2_32_buf and
//   compares every cycle against a pair of queue-based reference FIFOs.
module tb_demux1to2_32_buf;

    localparam int WIDTH = 32;
    localparam int DEPTH = 2;
    localparam int CW    = $clog2(DEPTH+1);

    logic             clk = 1'b0;
    logic             rst;
    logic [WIDTH-1:0] in_data;
    logic             in_select;
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] out0_data;
    logic             out0_valid;
    logic             out0_ready;
    logic [WIDTH-1:0] out1_data;
    logic             out1_valid;
    logic             out1_ready;
    logic [CW-1:0]    out0_count;
    logic [CW-1:0]    out1_count;

    demux1to2_32_buf #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
        .clk        (clk),
        .rst        (rst),
        .in_data    (in_data),
        .in_select  (in_select),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .out0_data  (out0_data),
        .out0_valid (out0_valid),
        .out0_ready (out0_ready),
        .out1_data  (out1_data),
        .out1_valid (out1_valid),
        .out1_ready (out1_ready),
        .out0_count (out0_count),
        .out1_count (out1_count)
    );

    always #5 clk = ~clk;

    int               checks   = 0;
    int               failures = 0;
    logic [WIDTH-1:0] m0[$];
    logic [WIDTH-1:0] m1[$];
    logic [WIDTH-1:0] got0[$];
    bit               acc;

    task automatic check(string tag, logic [63:0] obs, logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One cycle: drive after the falling edge, check against the model,
    // then advance the model by the transfers that happen at the rising edge.
    task automatic step(bit v, bit s, logic [WIDTH-1:0] d, bit r0, bit r1);
        bit er;
        @(negedge clk);
        in_valid = v; in_select = s; in_data = d; out0_ready = r0; out1_ready = r1;
        #1;
        er = s ? (m1.size() < DEPTH) : (m0.size() < DEPTH);
        check("in_ready",   64'(in_ready),   64'(er));
        check("out0_valid", 64'(out0_valid), 64'(m0.size() != 0));
        check("out1_valid", 64'(out1_valid), 64'(m1.size() != 0));
        check("out0_data",  64'(out0_data),  64'(m0.size() != 0 ? m0[0] : 32'h0));
        check("out1_data",  64'(out1_data),  64'(m1.size() != 0 ? m1[0] : 32'h0));
        check("out0_count", 64'(out0_count), 64'(m0.size()));
        check("out1_count", 64'(out1_count), 64'(m1.size()));
        @(posedge clk);
        if (r0 && m0.size() != 0) got0.push_back(m0.pop_front());
        if (r1 && m1.size() != 0) void'(m1.pop_front());
        acc = v && er;
        if (acc) begin
            if (s) m1.push_back(d);
            else   m0.push_back(d);
        end
    endtask

    task automatic async_reset();
        @(negedge clk);
        in_valid = 1'b0; out0_ready = 1'b0; out1_ready = 1'b0;
        #2;
        rst = 1'b1;
        #1;
        check("rst_out0_valid", 64'(out0_valid), 64'd0);
        check("rst_out1_valid", 64'(out1_valid), 64'd0);
        check("rst_out0_data",  64'(out0_data),  64'd0);
        check("rst_out1_data",  64'(out1_data),  64'd0);
        check("rst_out0_count", 64'(out0_count), 64'd0);
        check("rst_out1_count", 64'(out1_count), 64'd0);
        check("rst_in_ready",   64'(in_ready),   64'd1);
        m0.delete();
        m1.delete();
        @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        int next;
        rst = 1'b1; in_valid = 1'b0; in_select = 1'b0; in_data = '0;
        out0_ready = 1'b0; out1_ready = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b0;

        // Steering
        step(1, 0, 32'hAAAA0001, 0, 0);
        step(1, 1, 32'hBBBB0002, 0, 0);
        step(0, 0, 32'h0, 0, 0);
        check("steer_out0", 64'(out0_data), 64'hAAAA0001);
        check("steer_out1", 64'(out1_data), 64'hBBBB0002);

        // Full queue 0 stalls; queue 1 still accepts
        async_reset();
        step(1, 0, 32'h11, 0, 0);
        step(1, 0, 32'h22, 0, 0);
        step(1, 0, 32'h33, 0, 0);
        check("full_stall", 64'(acc), 64'd0);
        step(1, 0, 32'h33, 1, 0);
        check("full_no_bypass", 64'(acc), 64'd0);
        step(0, 1, 32'h0, 0, 0);
        check("full_other_ready", 64'(in_ready), 64'd1);

        // Wrap and FIFO order with toggling consumer ready
        async_reset();
        got0.delete();
        next = 1;
        for (int cyc = 0; cyc < 100 && (next <= 8 || m0.size() != 0); cyc++) begin
            step(next <= 8, 0, 32'(next), cyc[0], 0);
            if (acc) next++;
        end
        check("order_len", 64'(got0.size()), 64'd8);
        for (int i = 0; i < 8 && i < got0.size(); i++)
            check("order_word", 64'(got0[i]), 64'(i + 1));

        // Concurrent push and pop on queue 1
        async_reset();
        step(1, 1, 32'h5555, 0, 0);
        step(1, 1, 32'h6666, 0, 1);
        step(0, 0, 32'h0, 0, 0);
        check("conc_count", 64'(out1_count), 64'd1);
        check("conc_head",  64'(out1_data),  64'h6666);

        // Reset with both queues full
        for (int i = 0; i < 4; i++) step(1, i[0], $urandom, 0, 0);
        check("pre_rst_cnt0", 64'(out0_count), 64'd2);
        async_reset();
        step(1, 1, 32'hDEADBEEF, 0, 0);
        step(0, 0, 32'h0, 0, 0);
        check("post_rst_out1", 64'(out1_data),  64'hDEADBEEF);
        check("post_rst_cnt1", 64'(out1_count), 64'd1);
        check("post_rst_v0",   64'(out0_valid), 64'd0);

        // Random traffic
        for (int i = 0; i < 2000; i++)
            step($urandom_range(0, 3) != 0, $urandom_range(0, 1) == 1, $urandom,
                 $urandom_range(0, 2) != 0, $urandom_range(0, 2) == 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
